// File: rtl/seg_scan_if.sv
// ---------------------------------------------------------------------------
// seg_scan_if
//   Bundle between the host logic and seg_scan_driver.
//   Host side (master) drives: enable, value[15:0], dp_in[3:0], load.
//   Driver side (slave) drives: ack, select[3:0], seg_a..seg_d[7:0],
//   frame_done.
//   seg_a..seg_d are active-low patterns {dp,g,f,e,d,c,b,a}. They feed the
//   A..D inputs of seg_multiplexer. select goes to its select input, and
//   enable is passed straight through.
// ---------------------------------------------------------------------------
interface seg_scan_if;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        ack;
  logic [3:0]  select;
  logic [7:0]  seg_a;
  logic [7:0]  seg_b;
  logic [7:0]  seg_c;
  logic [7:0]  seg_d;
  logic        frame_done;

  modport master (
    output enable, value, dp_in, load,
    input  ack, select, seg_a, seg_b, seg_c, seg_d, frame_done
  );

  modport slave (
    input  enable, value, dp_in, load,
    output ack, select, seg_a, seg_b, seg_c, seg_d, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//   Four-digit seven-segment scan driver. It encodes a 16-bit hex value and
//   four decimal-point flags into active-low segment patterns. It also
//   rotates a one-hot digit select every PRESCALE cycles. New values are
//   held in a shadow register and only go live at a frame boundary, or
//   immediately while the scan is idle, so the display never tears.
//
//   Parameters
//     PRESCALE : clock cycles per digit slot (>= 2)
//   Ports
//     clk  : system clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : seg_scan_if.slave
//            enable, value, dp_in, load      (in)
//            ack, select, seg_a..seg_d,
//            frame_done                      (out, all registered)
//   Build option
//     SEG_LZ_BLANK_EN : when defined, leading-zero digits A..C are blanked.
//                       Digit D is never blanked. A blanked digit still
//                       shows its DP when the flag is set.
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int PRESCALE = 1000
) (
  input  logic     clk,
  input  logic     rst,
  seg_scan_if.slave bus
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN_A = 3'd1,
    ST_SCAN_B = 3'd2,
    ST_SCAN_C = 3'd3,
    ST_SCAN_D = 3'd4
  } state_t;

  // -------------------------------------------------------------------------
  // Encoding helpers
  // -------------------------------------------------------------------------
  function automatic logic [7:0] hex_pattern(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      4'hF: pat = 8'h8E;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  function automatic logic [7:0] apply_dp(input logic [7:0] pat, input logic dp);
    return dp ? {1'b0, pat[6:0]} : pat;
  endfunction

  // Returns {A, B, C, D} patterns packed into 32 bits, with A in [31:24].
  function automatic logic [31:0] encode_word(input logic [15:0] v,
                                              input logic [3:0]  dp);
    logic [3:0]  blank;
    logic [7:0]  pat;
    logic [31:0] res;
    blank = 4'b0000;
    res   = '0;
`ifdef SEG_LZ_BLANK_EN
    // A blank digit requires every more-significant nibble to be zero too.
    blank[3] = (v[15:12] == 4'h0);
    blank[2] = blank[3] && (v[11:8] == 4'h0);
    blank[1] = blank[2] && (v[7:4]  == 4'h0);
`endif
    for (int i = 0; i < 4; i++) begin
      pat = blank[i] ? 8'hFF : hex_pattern(v[i*4 +: 4]);
      res[i*8 +: 8] = apply_dp(pat, dp[i]);
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_select;
  logic [3:0]       w_select_nxt;

  logic [15:0]      r_pend_val;
  logic [3:0]       r_pend_dp;
  logic             r_pend_vld;

  logic [7:0]       r_seg_a, r_seg_b, r_seg_c, r_seg_d;
  logic             r_xfer_p0;
  logic             r_ack;
  logic             r_frame_done;

  logic             w_tick;
  logic             w_frame;
  logic             w_xfer_win;
  logic             w_xfer;
  logic [15:0]      w_src_val;
  logic [3:0]       w_src_dp;
  logic [31:0]      w_enc;
  logic [31:0]      w_rst_pat;

  // -------------------------------------------------------------------------
  // Scan FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_SCAN_A;
      r_cnt    <= '0;
      r_select <= 4'h1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_select <= w_select_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM: next state, prescaler and select decode
  // -------------------------------------------------------------------------
  assign w_tick = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_IDLE) begin
      // Restarting from zero gives the first slot its full length.
      w_state_nxt = ST_SCAN_A;
      w_cnt_nxt   = '0;
    end else if (w_tick) begin
      w_cnt_nxt = '0;
      case (r_state)
        ST_SCAN_A: w_state_nxt = ST_SCAN_B;
        ST_SCAN_B: w_state_nxt = ST_SCAN_C;
        ST_SCAN_C: w_state_nxt = ST_SCAN_D;
        ST_SCAN_D: w_state_nxt = ST_SCAN_A;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // select is registered alongside the state, so it is decoded from the
  // next state.
  always_comb begin
    w_select_nxt = 4'h0;
    case (w_state_nxt)
      ST_SCAN_A: w_select_nxt = 4'h1;
      ST_SCAN_B: w_select_nxt = 4'h2;
      ST_SCAN_C: w_select_nxt = 4'h4;
      ST_SCAN_D: w_select_nxt = 4'h8;
      default:   w_select_nxt = 4'h0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Transfer decision
  // -------------------------------------------------------------------------
  // A deasserting enable edge never counts as a frame boundary.
  assign w_frame    = bus.enable && (r_state == ST_SCAN_D) && w_tick;
  assign w_xfer_win = (r_state == ST_IDLE) || w_frame;
  assign w_xfer     = w_xfer_win && (bus.load || r_pend_vld);

  // A load on the transfer edge bypasses the shadow register.
  assign w_src_val  = bus.load ? bus.value : r_pend_val;
  assign w_src_dp   = bus.load ? bus.dp_in : r_pend_dp;
  assign w_enc      = encode_word(w_src_val, w_src_dp);
  assign w_rst_pat  = encode_word(16'h0000, 4'h0);

  // -------------------------------------------------------------------------
  // Stage p0: shadow register, segment patterns, transfer/frame flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_vld   <= 1'b0;
      r_seg_a      <= w_rst_pat[31:24];
      r_seg_b      <= w_rst_pat[23:16];
      r_seg_c      <= w_rst_pat[15:8];
      r_seg_d      <= w_rst_pat[7:0];
      r_xfer_p0    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_seg_a    <= w_enc[31:24];
        r_seg_b    <= w_enc[23:16];
        r_seg_c    <= w_enc[15:8];
        r_seg_d    <= w_enc[7:0];
        r_pend_vld <= 1'b0;
      end else if (bus.load) begin
        // The last load wins; overwriting a still-pending value gives no ack.
        r_pend_val <= bus.value;
        r_pend_dp  <= bus.dp_in;
        r_pend_vld <= 1'b1;
      end
      r_xfer_p0    <= w_xfer;
      r_frame_done <= w_frame;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: ack follows the first cycle of the new patterns
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
    end else begin
      // Back-to-back idle transfers must not stretch ack over two cycles.
      r_ack <= r_xfer_p0 && !r_ack;
    end
  end

  assign bus.select     = r_select;
  assign bus.seg_a      = r_seg_a;
  assign bus.seg_b      = r_seg_b;
  assign bus.seg_c      = r_seg_c;
  assign bus.seg_d      = r_seg_d;
  assign bus.ack        = r_ack;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int P = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_driver #(.PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state
  bit          m_scan;
  int          m_run;      // edges since the scan (re)started at digit A
  bit          m_pend_v;
  logic [15:0] m_pend_val;
  logic [3:0]  m_pend_dp;
  logic [15:0] m_disp_val;
  logic [3:0]  m_disp_dp;
  bit          m_xfer_d;
  bit          m_ack;
  bit          m_fd;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Digit d: 0 = A (value[15:12]) .. 3 = D (value[3:0])
  function automatic logic [7:0] model_seg(input logic [15:0] v, input logic [3:0] dp, input int d);
    logic [7:0] pat;
    int         nib;
    bit         blanked;
    nib     = (v >> (4 * (3 - d))) & 16'hF;
    blanked = 0;
`ifdef SEG_LZ_BLANK_EN
    if (d < 3) begin
      blanked = 1;
      for (int k = 0; k <= d; k++)
        if (((v >> (4 * (3 - k))) & 16'hF) != 0) blanked = 0;
    end
`endif
    pat = blanked ? 8'hFF : hex_tab[nib];
    if (dp[3 - d]) pat = pat & 8'h7F;
    return pat;
  endfunction

  function automatic logic [3:0] model_select();
    if (!m_scan) return 4'h0;
    return 4'(1 << ((m_run / P) % 4));
  endfunction

  task automatic model_edge(input bit r, input bit en, input bit ld,
                            input logic [15:0] v, input logic [3:0] dp);
    bit boundary, win, xfer;
    if (r) begin
      m_scan = 1; m_run = 0; m_pend_v = 0; m_pend_val = 0; m_pend_dp = 0;
      m_disp_val = 0; m_disp_dp = 0; m_xfer_d = 0; m_ack = 0; m_fd = 0;
    end else begin
      boundary = m_scan && en && (((m_run + 1) % (4 * P)) == 0);
      win      = !m_scan || boundary;
      xfer     = 0;
      if (win && ld) begin
        m_disp_val = v; m_disp_dp = dp; m_pend_v = 0; xfer = 1;
      end else if (win && m_pend_v) begin
        m_disp_val = m_pend_val; m_disp_dp = m_pend_dp; m_pend_v = 0; xfer = 1;
      end else if (ld) begin
        m_pend_val = v; m_pend_dp = dp; m_pend_v = 1;
      end
      m_ack    = m_xfer_d && !m_ack;
      m_xfer_d = xfer;
      m_fd     = boundary;
      if (!en) begin
        m_scan = 0; m_run = 0;
      end else if (!m_scan) begin
        m_scan = 1; m_run = 0;
      end else begin
        m_run++;
      end
    end
  endtask

  task automatic step(input bit r, input bit en, input bit ld,
                      input logic [15:0] v, input logic [3:0] dp);
    rst        = r;
    bus.enable = en;
    bus.load   = ld;
    bus.value  = v;
    bus.dp_in  = dp;
    @(posedge clk);
    model_edge(r, en, ld, v, dp);
    #1;
    check_eq("select",     16'(bus.select),     16'(model_select()));
    check_eq("seg_a",      16'(bus.seg_a),      16'(model_seg(m_disp_val, m_disp_dp, 0)));
    check_eq("seg_b",      16'(bus.seg_b),      16'(model_seg(m_disp_val, m_disp_dp, 1)));
    check_eq("seg_c",      16'(bus.seg_c),      16'(model_seg(m_disp_val, m_disp_dp, 2)));
    check_eq("seg_d",      16'(bus.seg_d),      16'(model_seg(m_disp_val, m_disp_dp, 3)));
    check_eq("ack",        16'(bus.ack),        16'(m_ack));
    check_eq("frame_done", 16'(bus.frame_done), 16'(m_fd));
  endtask

  task automatic idle_run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(0, en, 0, 16'h0, 4'h0);
  endtask

  initial begin
    bit          en, ld, prev_ld, r;
    logic [15:0] v;
    logic [3:0]  dp;

    // Reset and free-running scan
    step(1, 1, 0, 16'h0, 4'h0);
    step(1, 1, 0, 16'h0, 4'h0);
    check_eq("rst_select", 16'(bus.select), 16'h0001);
    check_eq("rst_ack",    16'(bus.ack),    16'h0000);
    check_eq("rst_seg_d",  16'(bus.seg_d),  16'h00C0);
    idle_run(34, 1);

    // Mid-frame load shows up only at the frame boundary
    idle_run(3, 1);
    step(0, 1, 1, 16'h4321, 4'h0);
    idle_run(20, 1);
    check_eq("dir_4321_a", 16'(bus.seg_a), 16'h0099);
    check_eq("dir_4321_d", 16'(bus.seg_d), 16'h00F9);

    // Two loads close together, last one wins
    step(0, 1, 1, 16'h1111, 4'h0);
    idle_run(2, 1);
    step(0, 1, 1, 16'hABCD, 4'b0001);
    idle_run(20, 1);

    // Disable, load while idle, re-enable
    step(0, 0, 0, 16'h0, 4'h0);
    check_eq("dis_select", 16'(bus.select), 16'h0000);
    step(0, 0, 1, 16'hF00E, 4'h0);
    check_eq("idle_seg_a", 16'(bus.seg_a), 16'h008E);
    check_eq("idle_seg_d", 16'(bus.seg_d), 16'h0086);
    step(0, 0, 0, 16'h0, 4'h0);
    check_eq("idle_ack",   16'(bus.ack),   16'h0001);
    idle_run(3, 0);
    idle_run(20, 1);

    // Load exactly on the frame-boundary edge
    for (int i = 0; i < 4 * P && !(m_scan && ((m_run + 1) % (4 * P)) == 0); i++)
      step(0, 1, 0, 16'h0, 4'h0);
    step(0, 1, 1, 16'h0007, 4'h0);
    check_eq("bnd_seg_d", 16'(bus.seg_d), 16'h00F8);
`ifdef SEG_LZ_BLANK_EN
    check_eq("bnd_seg_a", 16'(bus.seg_a), 16'h00FF);
`else
    check_eq("bnd_seg_a", 16'(bus.seg_a), 16'h00C0);
`endif
    idle_run(6, 1);

    // Reset mid-slot with a load still pending
    idle_run(2, 1);
    step(0, 1, 1, 16'h5A5A, 4'hF);
    step(1, 1, 0, 16'h0, 4'h0);
    idle_run(40, 1);

    // Randomised traffic
    prev_ld = 0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 19) != 0);
      ld = !prev_ld && ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 399) == 0);
      v  = 16'($urandom);
      case ($urandom_range(0, 4))
        0: v = v & 16'h000F;
        1: v = v & 16'h00FF;
        2: v = v & 16'h0FFF;
        default: ;
      endcase
      dp = 4'($urandom);
      step(r, en, ld, v, dp);
      prev_ld = ld;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
